clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_util_pkg.sv | 29 ++
 rtl/sync_ff.sv | 20 ++
 rtl/clk_period_meter.sv | 147 ++++++++++++++
 tb/tb_clk_period_meter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_util_pkg.sv
// Shared clock-utility definitions: period-meter state encoding and width helpers.
// Anything that measures or crosses slow clocks imports this package.
package clk_util_pkg;

    localparam int SYNC_MIN = 2;

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_TIMEOUT = 2'd3
    } meter_state_t;

    // Bits needed to hold the unsigned value 'value' (never less than 1).
    function automatic int int_width(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= value) w = i + 1;
        end
        return w;
    endfunction

    // Synchronizer depth actually built; shallower chains are not metastability-safe.
    function automatic int clamp_sync(input int stages);
        return (stages < SYNC_MIN) ? SYNC_MIN : stages;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared by synchronous reset.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_in,
    input  logic res_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk_in) begin
        if (!res_n) sr <= '0;
        else        sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk_in cycles,
// with a valid/ack handshake plus sticky overrun and overflow flags.
module clk_period_meter
    import clk_util_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             res_n,
    input  logic             sig_in,
    input  logic             meas_ack,
    output logic             sig_sync,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic             overrun,
    output logic             overflow
);

    localparam int              SYNC_N      = clamp_sync(SYNC_STAGES);
    localparam int              SW          = int_width(SYNC_N);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SYNC_N);
    // Last count at which MEASURE may still increment; the step to all-ones times out.
    localparam logic [WIDTH-1:0] CNT_LAST   = ~WIDTH'(1);

    logic             sync_q;
    logic             hist;
    logic             strobe_en;
    meter_state_t     state, state_nxt;
    logic [SW-1:0]    settle_cnt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_plus1;
    logic             settle_inc;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             latch_period;
    logic             latch_high;
    logic             set_ovf;

    sync_ff #(
        .STAGES(SYNC_N)
    ) u_sync (
        .clk_in(clk_in),
        .res_n (res_n),
        .d     (sig_in),
        .q     (sync_q)
    );

    assign sig_sync  = sync_q;
    assign cnt_plus1 = cnt + 1'b1;

    // Strobes stay quiet while the synchronizer refills after reset, so a level
    // held through reset never shows up as an edge.
    assign strobe_en = (state != ST_SETTLE);

    always_ff @(posedge clk_in) begin
        if (!res_n) begin
            hist     <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            hist     <= sync_q;
            rise_stb <= strobe_en & sync_q & ~hist;
            fall_stb <= strobe_en & ~sync_q & hist;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!res_n) state <= ST_SETTLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = ST_ARM;
            ST_ARM:     if (rise_stb) state_nxt = ST_MEASURE;
            ST_MEASURE: if (!rise_stb && cnt == CNT_LAST) state_nxt = ST_TIMEOUT;
            ST_TIMEOUT: if (rise_stb) state_nxt = ST_MEASURE;
            default:    state_nxt = ST_SETTLE;
        endcase
    end

    always_comb begin
        settle_inc   = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        latch_period = 1'b0;
        latch_high   = 1'b0;
        set_ovf      = 1'b0;
        case (state)
            ST_SETTLE: settle_inc = 1'b1;
            ST_ARM:    cnt_clr    = rise_stb;
            ST_MEASURE: begin
                if (rise_stb) begin
                    latch_period = 1'b1;
                    cnt_clr      = 1'b1;
                end else begin
                    cnt_inc    = 1'b1;
                    latch_high = fall_stb;
                    set_ovf    = (cnt == CNT_LAST);
                end
            end
            ST_TIMEOUT: cnt_clr = rise_stb;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!res_n) begin
            settle_cnt <= '0;
            cnt        <= '0;
        end else begin
            if (settle_inc) settle_cnt <= settle_cnt + 1'b1;
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt_plus1;
        end
    end

    // Result registers and handshake flags; a new result or a fresh overflow
    // always beats a coincident acknowledge.
    always_ff @(posedge clk_in) begin
        if (!res_n) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (latch_high)   high_time <= cnt_plus1;
            if (latch_period) period    <= cnt_plus1;

            if (latch_period)  meas_valid <= 1'b1;
            else if (meas_ack) meas_valid <= 1'b0;

            if (latch_period && meas_valid && !meas_ack) overrun <= 1'b1;
            else if (meas_ack)                           overrun <= 1'b0;

            if (set_ovf)       overflow <= 1'b1;
            else if (meas_ack) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized and directed checks of clk_period_meter against an edge-time reference model.
module tb_clk_period_meter;
    import clk_util_pkg::*;

    localparam int S16 = 2;
    localparam int S4  = 3;

    logic        clk_in = 1'b0;
    logic        res_n  = 1'b0;
    logic        sig_a  = 1'b0, ack_a = 1'b0;
    logic        sig_b  = 1'b0, ack_b = 1'b0;
    logic        sync_a, rise_a, fall_a, valid_a, ovr_a, ovf_a;
    logic [15:0] period_a, high_a;
    logic        sync_b, rise_b, fall_b, valid_b, ovr_b, ovf_b;
    logic [3:0]  period_b, high_b;

    int checks = 0;
    int errors = 0;

    bit sig_tab[0:511];
    bit ack_tab[0:511];
    int tlen;

    clk_period_meter #(.WIDTH(16), .SYNC_STAGES(S16)) u_d16 (
        .clk_in(clk_in), .res_n(res_n), .sig_in(sig_a), .meas_ack(ack_a),
        .sig_sync(sync_a), .rise_stb(rise_a), .fall_stb(fall_a),
        .period(period_a), .high_time(high_a), .meas_valid(valid_a),
        .overrun(ovr_a), .overflow(ovf_a));

    clk_period_meter #(.WIDTH(4), .SYNC_STAGES(S4)) u_d4 (
        .clk_in(clk_in), .res_n(res_n), .sig_in(sig_b), .meas_ack(ack_b),
        .sig_sync(sync_b), .rise_stb(rise_b), .fall_stb(fall_b),
        .period(period_b), .high_time(high_b), .meas_valid(valid_b),
        .overrun(ovr_b), .overflow(ovf_b));

    always #5 clk_in = ~clk_in;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset(input int n, input bit lvl);
        res_n = 1'b0;
        sig_a = lvl;
        ack_a = 1'b0;
        step(n);
    endtask

    task automatic tab_clear();
        tlen = 0;
    endtask

    task automatic tab_push(input bit s, input bit a, input int n);
        repeat (n) begin
            sig_tab[tlen] = s;
            ack_tab[tlen] = a;
            tlen++;
        end
    endtask

    task automatic tab_square(input int hi, input int lo, input int n);
        repeat (n) begin
            tab_push(1'b1, 1'b0, hi);
            tab_push(1'b0, 1'b0, lo);
        end
    endtask

    // Plays sig_tab/ack_tab into the WIDTH=16 meter from reset release. Expected
    // strobes sit a fixed latency after each input edge, and results are pure
    // differences between strobe times once a first rise has armed the meter.
    task automatic run_table(input string name, input bit init_lvl);
        bit rise_e[0:1023];
        bit fall_e[0:1023];
        bit prev, have_rise, lat, r, f, a;
        int last_rise, total;
        int exp_period, exp_high;
        bit exp_valid, exp_ovr;
        rise_e = '{default: 1'b0};
        fall_e = '{default: 1'b0};
        prev = init_lvl;
        for (int k = 0; k < tlen; k++) begin
            if (k > 0 && sig_tab[k] && !prev) rise_e[k + 1 + S16] = 1'b1;
            if (k > 0 && !sig_tab[k] && prev) fall_e[k + 1 + S16] = 1'b1;
            prev = sig_tab[k];
        end
        have_rise = 1'b0; last_rise = 0;
        exp_period = 0; exp_high = 0; exp_valid = 1'b0; exp_ovr = 1'b0;
        total = tlen + S16 + 3;
        res_n = 1'b1;
        for (int s = 1; s <= total; s++) begin
            sig_a = (s - 1 < tlen) ? sig_tab[s-1] : sig_tab[tlen-1];
            a     = (s - 1 < tlen) ? ack_tab[s-1] : 1'b0;
            ack_a = a;
            step(1);
            r = rise_e[s-1];
            f = fall_e[s-1];
            lat = 1'b0;
            if (r) begin
                if (have_rise) begin
                    lat = 1'b1;
                    exp_period = (s - 1) - last_rise;
                end
                have_rise = 1'b1;
                last_rise = s - 1;
            end
            if (f && have_rise) exp_high = (s - 1) - last_rise;
            if (lat && exp_valid && !a) exp_ovr = 1'b1;
            else if (a)                 exp_ovr = 1'b0;
            if (lat)    exp_valid = 1'b1;
            else if (a) exp_valid = 1'b0;

            checks += 7;
            if (rise_a !== rise_e[s]) begin
                errors++;
                $display("FAIL %s step %0d rise_stb: got %0b expected %0b", name, s, rise_a, rise_e[s]);
            end
            if (fall_a !== fall_e[s]) begin
                errors++;
                $display("FAIL %s step %0d fall_stb: got %0b expected %0b", name, s, fall_a, fall_e[s]);
            end
            if (period_a !== 16'(exp_period)) begin
                errors++;
                $display("FAIL %s step %0d period: got %0d expected %0d", name, s, period_a, exp_period);
            end
            if (high_a !== 16'(exp_high)) begin
                errors++;
                $display("FAIL %s step %0d high_time: got %0d expected %0d", name, s, high_a, exp_high);
            end
            if (valid_a !== exp_valid) begin
                errors++;
                $display("FAIL %s step %0d meas_valid: got %0b expected %0b", name, s, valid_a, exp_valid);
            end
            if (ovr_a !== exp_ovr) begin
                errors++;
                $display("FAIL %s step %0d overrun: got %0b expected %0b", name, s, ovr_a, exp_ovr);
            end
            if (ovf_a !== 1'b0) begin
                errors++;
                $display("FAIL %s step %0d overflow: got %0b expected 0", name, s, ovf_a);
            end
        end
        ack_a = 1'b0;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        sig_a = 1'($urandom_range(0, 1));
        sig_b = 1'($urandom_range(0, 1));
        ack_a = 1'($urandom_range(0, 1));
        ack_b = 1'($urandom_range(0, 1));
        step(3);
        checks += 10;
        if ({sync_a, rise_a, fall_a, valid_a, ovr_a, ovf_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset flags16: got %b expected 000000", {sync_a, rise_a, fall_a, valid_a, ovr_a, ovf_a});
        end
        if (period_a !== 16'd0) begin errors++; $display("FAIL reset period16: got %0d expected 0", period_a); end
        if (high_a !== 16'd0)   begin errors++; $display("FAIL reset high16: got %0d expected 0", high_a); end
        if ({sync_b, rise_b, fall_b, valid_b, ovr_b, ovf_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset flags4: got %b expected 000000", {sync_b, rise_b, fall_b, valid_b, ovr_b, ovf_b});
        end
        if (period_b !== 4'd0) begin errors++; $display("FAIL reset period4: got %0d expected 0", period_b); end
        if (high_b !== 4'd0)   begin errors++; $display("FAIL reset high4: got %0d expected 0", high_b); end
        if (u_d16.state !== ST_SETTLE) begin errors++; $display("FAIL reset state16: got %0d expected %0d", u_d16.state, ST_SETTLE); end
        if (u_d4.state !== ST_SETTLE)  begin errors++; $display("FAIL reset state4: got %0d expected %0d", u_d4.state, ST_SETTLE); end
        if (u_d16.cnt !== 16'd0) begin errors++; $display("FAIL reset cnt16: got %0d expected 0", u_d16.cnt); end
        if (u_d16.hist !== 1'b0) begin errors++; $display("FAIL reset hist16: got %0b expected 0", u_d16.hist); end
        sig_a = 1'b0; sig_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    endtask

    task automatic test_square_4_4();
        do_reset(2, 1'b0);
        tab_clear();
        tab_push(1'b0, 1'b0, 6);
        tab_square(4, 4, 3);
        run_table("sq44", 1'b0);
        checks += 3;
        if (period_a !== 16'd8) begin errors++; $display("FAIL sq44_final period: got %0d expected 8", period_a); end
        if (high_a !== 16'd4)   begin errors++; $display("FAIL sq44_final high_time: got %0d expected 4", high_a); end
        if (valid_a !== 1'b1)   begin errors++; $display("FAIL sq44_final meas_valid: got %0b expected 1", valid_a); end
    endtask

    task automatic test_3_7_ack();
        do_reset(2, 1'b0);
        tab_clear();
        tab_push(1'b0, 1'b0, 6);
        tab_square(3, 7, 3);
        ack_tab[16 + S16 + 2] = 1'b1;
        run_table("hi3lo7", 1'b0);
        checks += 2;
        if (period_a !== 16'd10) begin errors++; $display("FAIL hi3lo7_final period: got %0d expected 10", period_a); end
        if (high_a !== 16'd3)    begin errors++; $display("FAIL hi3lo7_final high_time: got %0d expected 3", high_a); end
    endtask

    task automatic test_overrun();
        do_reset(2, 1'b0);
        tab_clear();
        tab_push(1'b0, 1'b0, 6);
        tab_square(4, 4, 5);
        ack_tab[30 + S16 + 1] = 1'b1;
        run_table("overrun", 1'b0);
        checks += 3;
        if (period_a !== 16'd8) begin errors++; $display("FAIL overrun_final period: got %0d expected 8", period_a); end
        if (valid_a !== 1'b1)   begin errors++; $display("FAIL overrun_final meas_valid: got %0b expected 1", valid_a); end
        if (ovr_a !== 1'b1)     begin errors++; $display("FAIL overrun_final overrun: got %0b expected 1", ovr_a); end
    endtask

    task automatic test_settle_high();
        do_reset(2, 1'b1);
        tab_clear();
        tab_push(1'b1, 1'b0, 20);
        tab_push(1'b0, 1'b0, 10);
        tab_square(4, 6, 2);
        run_table("settle_hi", 1'b1);
    endtask

    task automatic test_midreset();
        do_reset(2, 1'b0);
        tab_clear();
        tab_push(1'b0, 1'b0, 6);
        tab_square(4, 4, 2);
        tab_push(1'b1, 1'b0, 3);
        run_table("pre_rst", 1'b0);
        res_n = 1'b0;
        step(1);
        checks += 4;
        if ({sync_a, rise_a, fall_a, valid_a, ovr_a, ovf_a} !== 6'b0) begin
            errors++;
            $display("FAIL midrst flags: got %b expected 000000", {sync_a, rise_a, fall_a, valid_a, ovr_a, ovf_a});
        end
        if (period_a !== 16'd0) begin errors++; $display("FAIL midrst period: got %0d expected 0", period_a); end
        if (high_a !== 16'd0)   begin errors++; $display("FAIL midrst high_time: got %0d expected 0", high_a); end
        if (u_d16.state !== ST_SETTLE) begin errors++; $display("FAIL midrst state: got %0d expected %0d", u_d16.state, ST_SETTLE); end
        tab_clear();
        tab_push(1'b1, 1'b0, 1);
        tab_push(1'b0, 1'b0, 4);
        tab_square(4, 4, 3);
        run_table("post_rst", 1'b1);
    endtask

    task automatic test_random();
        int hi, lo;
        for (int rep = 0; rep < 3; rep++) begin
            do_reset(2, 1'b0);
            tab_clear();
            tab_push(1'b0, 1'b0, 6);
            for (int p = 0; p < 12; p++) begin
                hi = $urandom_range(2, 12);
                lo = $urandom_range(2, 12);
                for (int i = 0; i < hi; i++) tab_push(1'b1, ($urandom_range(0, 3) == 0), 1);
                for (int i = 0; i < lo; i++) tab_push(1'b0, ($urandom_range(0, 3) == 0), 1);
            end
            run_table("random", 1'b0);
        end
    endtask

    // WIDTH=4: one rise then stuck high must time out when the count hits 15.
    task automatic test_overflow_w4();
        res_n = 1'b0; sig_b = 1'b0; ack_b = 1'b0;
        step(2);
        res_n = 1'b1;
        step(8);
        sig_b = 1'b1;
        step(S4 + 1);
        checks += 1;
        if (rise_b !== 1'b1) begin errors++; $display("FAIL w4 rise_stb: got %0b expected 1", rise_b); end
        step(15);
        checks += 2;
        if (ovf_b !== 1'b0) begin errors++; $display("FAIL w4 pre_ovf overflow: got %0b expected 0", ovf_b); end
        if (u_d4.state !== ST_MEASURE) begin errors++; $display("FAIL w4 pre_ovf state: got %0d expected %0d", u_d4.state, ST_MEASURE); end
        step(1);
        checks += 5;
        if (ovf_b !== 1'b1) begin errors++; $display("FAIL w4 ovf overflow: got %0b expected 1", ovf_b); end
        if (u_d4.state !== ST_TIMEOUT) begin errors++; $display("FAIL w4 ovf state: got %0d expected %0d", u_d4.state, ST_TIMEOUT); end
        if (u_d4.cnt !== 4'd15) begin errors++; $display("FAIL w4 ovf cnt: got %0d expected 15", u_d4.cnt); end
        if (period_b !== 4'd0 || high_b !== 4'd0) begin
            errors++;
            $display("FAIL w4 ovf results: got %0d/%0d expected 0/0", period_b, high_b);
        end
        if (valid_b !== 1'b0) begin errors++; $display("FAIL w4 ovf meas_valid: got %0b expected 0", valid_b); end
        step(10);
        checks += 2;
        if (u_d4.state !== ST_TIMEOUT || ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL w4 hold state/overflow: got %0d/%0b expected %0d/1", u_d4.state, ovf_b, ST_TIMEOUT);
        end
        if (u_d4.cnt !== 4'd15) begin errors++; $display("FAIL w4 hold cnt: got %0d expected 15", u_d4.cnt); end
        sig_b = 1'b0;
        step(6);
        sig_b = 1'b1;
        step(3);
        sig_b = 1'b0;
        step(2);
        checks += 3;
        if (u_d4.state !== ST_MEASURE) begin errors++; $display("FAIL w4 rearm state: got %0d expected %0d", u_d4.state, ST_MEASURE); end
        if (valid_b !== 1'b0) begin errors++; $display("FAIL w4 rearm meas_valid: got %0b expected 0", valid_b); end
        if (ovf_b !== 1'b1) begin errors++; $display("FAIL w4 rearm overflow: got %0b expected 1", ovf_b); end
        ack_b = 1'b1;
        step(1);
        ack_b = 1'b0;
        checks += 1;
        if (ovf_b !== 1'b0) begin errors++; $display("FAIL w4 ack overflow: got %0b expected 0", ovf_b); end
        step(1);
        sig_b = 1'b1;
        step(S4 + 2);
        checks += 3;
        if (period_b !== 4'd7) begin errors++; $display("FAIL w4 result period: got %0d expected 7", period_b); end
        if (high_b !== 4'd3)   begin errors++; $display("FAIL w4 result high_time: got %0d expected 3", high_b); end
        if (valid_b !== 1'b1)  begin errors++; $display("FAIL w4 result meas_valid: got %0b expected 1", valid_b); end
        sig_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_square_4_4();
        test_3_7_ack();
        test_overrun();
        test_settle_high();
        test_midreset();
        test_random();
        test_overflow_w4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
